// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/sub sequencer.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_full_cell.sv
// 1-bit full adder: two half-adder stages with the stage carries ORed.
module bit_full_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;
  logic w_g0;
  logic w_g1;

  assign w_p  = a ^ b;
  assign w_g0 = a & b;
  assign s    = w_p ^ cin;
  assign w_g1 = w_p & cin;
  assign cout = w_g0 | w_g1;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial W-bit adder/subtractor sequencer, LSB first over W cycles.
// Optional out_ovf signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
`ifdef SERIAL_ADDSUB_OVF_EN
 ,output logic         out_ovf
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_mode;
  logic             r_cout;
  logic             w_s;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  bit_full_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CNT_W'(W - 1));
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The sum bits are shifted into the vacated MSBs of the A register; the
  // visible result register is written only once, on the final RUN cycle,
  // so out_sum never shows partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_mode  <= MODE_ADD;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= (in_sub == MODE_SUB) ? ~in_b : in_b;
      r_carry <= in_sub;
      r_mode  <= in_sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= {w_s, r_a[W-1:1]};
      r_b     <= {1'b0, r_b[W-1:1]};
      r_carry <= w_cout;
      if (w_last) begin
        r_sum  <= {w_s, r_a[W-1:1]};
        r_cout <= (r_mode == MODE_ADD) ? w_cout : ~w_cout;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;

  // On the MSB cycle r_carry is the carry into the MSB and w_cout the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= r_carry ^ w_cout;
  end

  assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl against a behavioural A+/-B model.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         out_ovf;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_out = 0;

  serial_addsub_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SERIAL_ADDSUB_OVF_EN
   ,.out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: result modulo 2^W, carry / borrow, signed overflow.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] s, output logic c, output logic v);
    logic [W:0] t;
    if (sub) begin
      s = a - b;
      c = (a < b);
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      s = t[W-1:0];
      c = t[W];
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
  endfunction

  // Model of the transaction level: one op in flight, result due W+1 negedges
  // after the negedge where the accept is observed.
  logic         m_pending = 1'b0;
  int           m_ready_at = 0;
  logic [W-1:0] m_s = '0, m_last_s = '0;
  logic         m_c = 1'b0, m_last_c = 1'b0;
  logic         m_v = 1'b0, m_last_v = 1'b0;
  logic         m_ov;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_pending = 1'b0;
      m_last_s  = '0;
      m_last_c  = 1'b0;
      m_last_v  = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sum", out_sum, '0);
      chk("rst_out_cout", out_cout, 1'b0);
`ifdef SERIAL_ADDSUB_OVF_EN
      chk("rst_out_ovf", out_ovf, 1'b0);
`endif
    end else begin
      m_ov = m_pending && (cyc >= m_ready_at);
      chk("in_ready", in_ready, !m_pending);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_sum", out_sum, m_s);
        chk("out_cout", out_cout, m_c);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("out_ovf", out_ovf, m_v);
`endif
        m_last_s = m_s;
        m_last_c = m_c;
        m_last_v = m_v;
      end else if (!m_pending) begin
        chk("idle_sum", out_sum, m_last_s);
        chk("idle_cout", out_cout, m_last_c);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("idle_ovf", out_ovf, m_last_v);
`endif
      end
      if (m_ov && out_ready) begin
        m_pending = 1'b0;
        n_out++;
      end else if (!m_pending && in_valid) begin
        ref_op(in_a, in_b, in_sub, m_s, m_c, m_v);
        m_pending  = 1'b1;
        m_ready_at = cyc + W + 1;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready never seen for a=%0h b=%0h", a, b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
  endtask

  task automatic wait_result(input bit rnd);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin ok = 1; break; end
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL result_timeout: out_valid/out_ready handshake not seen");
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    out_ready = 1'b1;
    send(a, b, sub);
    wait_result(1'b0);
    chk("lit_sum", out_sum, es);
    chk("lit_cout", out_cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("lit_ovf", out_ovf, ev);
`else
    if (ev === 1'bx) $display("ovf literal undefined");
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

    // Backpressure: result held while new operands are offered and ignored.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_sum", out_sum, 8'h46);
      chk("bp_cout", out_cout, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);

    // Asynchronous reset in the middle of RUN.
    send(8'h11, 8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_sum", out_sum, '0);
    chk("arst_cout", out_cout, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Random stream with random consumer backpressure.
    base = n_out;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      out_ready = ($urandom_range(0, 1) != 0);
      send(W'($urandom), W'($urandom), 1'($urandom));
      wait_result(1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("stream_count", n_out - base, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
